// File: rtl/arm_mem_pkg.sv
// rtl/arm_mem_pkg.sv - shared types and constants for the fetch/data memory arbiter
package arm_mem_pkg;
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } arb_state_e;

   localparam logic WIN_IF = 1'b0;
   localparam logic WIN_D  = 1'b1;

   localparam int DEF_ADDR_W       = 32;
   localparam int DEF_DATA_W       = 32;
   localparam int DEF_STARVE_LIMIT = 4;

   function automatic logic is_misaligned(input logic [1:0] lsb);
      return lsb != 2'b00;
   endfunction
endpackage

// File: rtl/arm_mem_prio_sel.sv
// rtl/arm_mem_prio_sel.sv - fetch/data winner select with anti-starvation counter
module arm_mem_prio_sel import arm_mem_pkg::*; #(
   parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
   input  logic clk,
   input  logic rst,
   input  logic if_req_i,
   input  logic d_req_i,
   input  logic grant_i,
   output logic winner_o
);
   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic [3:0] cnt_q, cnt_d;

   // Data normally wins; a fetch that has waited LIMIT data grants goes next.
   always_comb begin
      winner_o = WIN_IF;
      if (d_req_i && !(if_req_i && cnt_q == LIMIT)) winner_o = WIN_D;
   end

   always_comb begin
      cnt_d = cnt_q;
      if (grant_i) begin
         if (winner_o == WIN_IF)              cnt_d = '0;
         else if (if_req_i && cnt_q != LIMIT) cnt_d = cnt_q + 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end
endmodule

// File: rtl/arm_mem_arbiter.sv
// rtl/arm_mem_arbiter.sv - arbitrates instruction fetch and data ports onto one memory port
module arm_mem_arbiter import arm_mem_pkg::*; #(
   parameter int ADDR_W       = DEF_ADDR_W,
   parameter int DATA_W       = DEF_DATA_W,
   parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ack,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_err,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ack,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_data_in,
   output logic              mem_write_en,
   input  logic [DATA_W-1:0] mem_data_out,
   output logic              busy
);
   arb_state_e        state_q, state_d;
   logic              winner_q, winner_sel, we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q, if_rdata_q, d_rdata_q, rdata_val;
   logic              if_err_q, d_err_q;
   logic              grant, misaligned, resp_if, resp_d;

   assign grant = (state_q == IDLE) && (if_req || d_req);

   arm_mem_prio_sel #(.STARVE_LIMIT(STARVE_LIMIT)) u_prio (
      .clk      (clk),
      .rst      (rst),
      .if_req_i (if_req),
      .d_req_i  (d_req),
      .grant_i  (grant),
      .winner_o (winner_sel)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (if_req || d_req) state_d = ACCESS;
         ACCESS:  state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign misaligned = is_misaligned(addr_q[1:0]);
   assign rdata_val  = misaligned ? '0 : mem_data_out;
   assign resp_if    = !rst && (state_q == RESP) && (winner_q == WIN_IF);
   assign resp_d     = !rst && (state_q == RESP) && (winner_q == WIN_D);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         winner_q   <= WIN_IF;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
         if_err_q   <= 1'b0;
         d_err_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (grant) begin
            winner_q <= winner_sel;
            we_q     <= (winner_sel == WIN_D) && d_we;
            addr_q   <= (winner_sel == WIN_D) ? d_addr : if_addr;
            if (winner_sel == WIN_D) wdata_q <= d_wdata;
         end
         if (resp_if) begin
            if_rdata_q <= rdata_val;
            if_err_q   <= misaligned;
         end
         if (resp_d) begin
            d_rdata_q <= rdata_val;
            d_err_q   <= misaligned;
         end
      end
   end

   // Response fields are live during RESP and held afterwards; reset forces them low.
   assign if_ack   = resp_if;
   assign d_ack    = resp_d;
   assign if_rdata = rst ? '0 : (resp_if ? rdata_val : if_rdata_q);
   assign d_rdata  = rst ? '0 : (resp_d ? rdata_val : d_rdata_q);
   assign if_err   = !rst && (resp_if ? misaligned : if_err_q);
   assign d_err    = !rst && (resp_d ? misaligned : d_err_q);

   assign mem_addr     = addr_q;
   assign mem_data_in  = wdata_q;
   assign mem_write_en = !rst && (state_q == ACCESS) && we_q && (winner_q == WIN_D) && !misaligned;
   assign busy         = !rst && (state_q != IDLE);
endmodule

// File: tb/tb_arm_mem_arbiter.sv
// tb/tb_arm_mem_arbiter.sv - directed and randomized checks of arm_mem_arbiter against a transaction model
module tb_arm_mem_arbiter;
   localparam int LIM = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, d_req, d_we;
   logic [31:0] if_addr, d_addr, d_wdata;
   logic        if_ack, if_err, d_ack, d_err, mem_write_en, busy;
   logic [31:0] if_rdata, d_rdata, mem_addr, mem_data_in, mem_data_out;

   logic [31:0] mem [0:1023];
   bit   [1023:0] mem_written;
   logic [31:0] ref_mem [0:1023];
   int          checks = 0;
   int          errors = 0;
   int          we_cycles = 0;
   int          starve = 0;
   logic        wd;

   always #5 clk = ~clk;

   arm_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIM)) dut (
      .clk          (clk),
      .rst          (rst),
      .if_req       (if_req),
      .if_addr      (if_addr),
      .if_ack       (if_ack),
      .if_rdata     (if_rdata),
      .if_err       (if_err),
      .d_req        (d_req),
      .d_we         (d_we),
      .d_addr       (d_addr),
      .d_wdata      (d_wdata),
      .d_ack        (d_ack),
      .d_rdata      (d_rdata),
      .d_err        (d_err),
      .mem_addr     (mem_addr),
      .mem_data_in  (mem_data_in),
      .mem_write_en (mem_write_en),
      .mem_data_out (mem_data_out),
      .busy         (busy)
   );

   function automatic logic [31:0] init_word(input int i);
      if (i == 4) return 32'hE3A00001;
      return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
   endfunction

   function automatic logic [31:0] mem_word(input logic [9:0] idx);
      return mem_written[idx] ? mem[idx] : init_word(int'(idx));
   endfunction

   always @(posedge clk) begin
      if (mem_write_en) begin
         mem[mem_addr[11:2]]         <= mem_data_in;
         mem_written[mem_addr[11:2]] <= 1'b1;
         we_cycles                   <= we_cycles + 1;
      end
      mem_data_out <= mem_word(mem_addr[11:2]);
   end

   initial begin
      #2000000;
      $display("FAIL timeout observed=hang expected=finish");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] a;
      a = 32'($urandom_range(0, 1023)) << 2;
      if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
      return a;
   endfunction

   // Called at the falling edge of an IDLE cycle whose request inputs are already set;
   // returns at the falling edge of the RESP cycle.
   task automatic transact(output logic won_d);
      logic        exp_d, w, mis;
      logic [31:0] a, exp_rd;
      int          we0;
      exp_d  = d_req && !(if_req && starve == LIM);
      a      = exp_d ? d_addr : if_addr;
      w      = exp_d && d_we;
      mis    = (a[1:0] != 2'b00);
      exp_rd = mis ? 32'h0 : ref_mem[a[11:2]];
      if (exp_d && if_req) starve = (starve < LIM) ? starve + 1 : LIM;
      else if (!exp_d)     starve = 0;
      we0 = we_cycles;
      check("busy_idle", 32'(busy), 32'(0));
      @(negedge clk);
      check("busy_access", 32'(busy), 32'(1));
      check("acks_access", 32'({if_ack, d_ack}), 32'(0));
      check("mem_addr", mem_addr, a);
      check("mem_we", 32'(mem_write_en), 32'(w && !mis));
      if (w) check("mem_wdata", mem_data_in, d_wdata);
      @(negedge clk);
      check("if_ack", 32'(if_ack), 32'(!exp_d));
      check("d_ack", 32'(d_ack), 32'(exp_d));
      if (exp_d) begin
         if (!w) check("d_rdata", d_rdata, exp_rd);
         check("d_err", 32'(d_err), 32'(mis));
      end else begin
         check("if_rdata", if_rdata, exp_rd);
         check("if_err", 32'(if_err), 32'(mis));
      end
      if (w && !mis) ref_mem[a[11:2]] = d_wdata;
      check("we_count", 32'(we_cycles - we0), (w && !mis) ? 32'd1 : 32'd0);
      check("mem_word", mem_word(a[11:2]), ref_mem[a[11:2]]);
      won_d = exp_d;
   endtask

   initial begin
      rst = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      if_addr = '0; d_addr = '0; d_wdata = '0;
      for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
      @(negedge clk);
      check("rst_acks", 32'({if_ack, d_ack}), 32'(0));
      check("rst_errs", 32'({if_err, d_err}), 32'(0));
      check("rst_we", 32'(mem_write_en), 32'(0));
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_rdata", if_rdata | d_rdata, 32'h0);
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_mem_wdata", mem_data_in, 32'h0);
      rst = 1'b0;

      // single fetch
      if_addr = 32'h10; if_req = 1'b1;
      transact(wd);
      check("fetch_word", if_rdata, 32'hE3A00001);
      check("fetch_err", 32'(if_err), 32'(0));
      if_req = 1'b0;
      @(negedge clk);
      check("fetch_hold", if_rdata, 32'hE3A00001);
      check("hold_noack", 32'(if_ack), 32'(0));

      // write then read back
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF;
      transact(wd);
      d_we = 1'b0;
      @(negedge clk);
      transact(wd);
      check("readback", d_rdata, 32'hDEADBEEF);
      d_req = 1'b0;
      @(negedge clk);

      // misaligned write
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h102; d_wdata = 32'h0BADF00D;
      transact(wd);
      check("misalign_err", 32'(d_err), 32'(1));
      check("misalign_rdata", d_rdata, 32'h0);
      d_req = 1'b0; d_we = 1'b0;
      @(negedge clk);

      // both held: D,D,D,D,IF repeating
      if_addr = 32'h20; d_addr = 32'h40; d_we = 1'b0; if_req = 1'b1; d_req = 1'b1;
      for (int k = 0; k < 10; k++) begin
         transact(wd);
         check("grant_seq", 32'(wd), 32'((k % 5) != 4));
         @(negedge clk);
      end

      // reset during a write access
      transact(wd);
      @(negedge clk);
      transact(wd);
      if_req = 1'b0; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'h12345678;
      @(negedge clk);
      @(negedge clk);
      check("pre_rst_we", 32'(mem_write_en), 32'(1));
      rst = 1'b1; d_req = 1'b0; d_we = 1'b0;
      #1;
      check("rst_gate_we", 32'(mem_write_en), 32'(0));
      check("rst_gate_busy", 32'(busy), 32'(0));
      @(negedge clk);
      check("rst_no_ack", 32'(d_ack), 32'(0));
      rst = 1'b0; starve = 0;
      check("rst_no_write", mem_word(10'h080), ref_mem[10'h080]);
      @(negedge clk);
      check("post_rst_busy", 32'(busy), 32'(0));
      if_addr = 32'h24; d_addr = 32'h44; if_req = 1'b1; d_req = 1'b1;
      for (int k = 0; k < 5; k++) begin
         transact(wd);
         check("post_rst_seq", 32'(wd), 32'(k != 4));
         @(negedge clk);
      end
      if_req = 1'b0; d_req = 1'b0;

      // randomized traffic
      for (int n = 0; n < 300; n++) begin
         if (!if_req && $urandom_range(0, 2) != 0) begin
            if_req = 1'b1; if_addr = rand_addr();
         end
         if (!d_req && $urandom_range(0, 2) != 0) begin
            d_req = 1'b1; d_we = 1'($urandom_range(0, 1));
            d_addr = rand_addr(); d_wdata = $urandom;
         end
         if (!if_req && !d_req) begin
            check("idle_busy", 32'(busy), 32'(0));
            check("idle_acks", 32'({if_ack, d_ack}), 32'(0));
            @(negedge clk);
         end else begin
            transact(wd);
            if (wd) d_req = 1'b0;
            else    if_req = 1'b0;
            @(negedge clk);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
